// File: rtl/mnist_defs.sv
// Shared definitions for the MNIST frame core.
// Holds default network dimensions and the frame-sequencer state encoding.
package mnist_defs;

  localparam int unsigned IMG_W_DEF       = 28;
  localparam int unsigned IMG_H_DEF       = 28;
  localparam int unsigned PIX_W_DEF       = 8;
  localparam int unsigned LOGIT_W_DEF     = 32;
  localparam int unsigned NUM_CLASSES_DEF = 10;
  localparam int unsigned TIMEOUT_DEF     = 65535;

  typedef enum logic [1:0] {
    StLoad = 2'd0,
    StPad  = 2'd1,
    StWait = 2'd2,
    StHold = 2'd3
  } state_e;

endpackage

// File: rtl/mnist_argmax_seq.sv
// Sequential argmax over a serial logit stream.
// Ports:
//   clk_i, rst_ni  clock, async active-low reset
//   clear_i        zero best value/index and beat count
//   valid_i        one logit beat on data_i (signed)
//   best_idx_o     index of the largest logit seen so far (first wins on ties)
//   best_val_o     value of that logit
//   count_o        number of beats taken since the last clear
module mnist_argmax_seq #(
  parameter int unsigned LOGIT_W     = 32,
  parameter int unsigned NUM_CLASSES = 10
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic                                 clear_i,
  input  logic                                 valid_i,
  input  logic signed [LOGIT_W-1:0]            data_i,
  output logic        [$clog2(NUM_CLASSES)-1:0]   best_idx_o,
  output logic signed [LOGIT_W-1:0]            best_val_o,
  output logic        [$clog2(NUM_CLASSES+1)-1:0] count_o
);

  localparam int unsigned CLS_W = $clog2(NUM_CLASSES);
  localparam int unsigned CNT_W = $clog2(NUM_CLASSES + 1);

  logic        [CLS_W-1:0]   idx_q, idx_d;
  logic signed [LOGIT_W-1:0] val_q, val_d;
  logic        [CNT_W-1:0]   cnt_q, cnt_d;
  logic                      take;

  // The first beat after a clear always loads; later beats need a strict win.
  assign take = (cnt_q == '0) || (data_i > val_q);

  always_comb begin
    idx_d = idx_q;
    val_d = val_q;
    cnt_d = cnt_q;
    if (clear_i) begin
      idx_d = '0;
      val_d = '0;
      cnt_d = '0;
    end else if (valid_i) begin
      cnt_d = cnt_q + CNT_W'(1);
      if (take) begin
        idx_d = cnt_q[CLS_W-1:0];
        val_d = data_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      idx_q <= '0;
      val_q <= '0;
      cnt_q <= '0;
    end else begin
      idx_q <= idx_d;
      val_q <= val_d;
      cnt_q <= cnt_d;
    end
  end

  assign best_idx_o = idx_q;
  assign best_val_o = val_q;
  assign count_o    = cnt_q;

endmodule

// File: rtl/mnist_frame_core.sv
// Frame sequencer around the layer1..layer4 datapath.
// Ports:
//   clk_i, rst_ni            clock, async active-low reset (shared with layer blocks)
//   s_valid_i/s_ready_o      pixel intake handshake; s_pixel_i data, s_last_i end of frame
//   net_valid_o/net_pixel_o  registered pixel strobe into layer1 (zero pixels while padding)
//   net_logit_valid_i/_i     serial logits from layer4, class order 0..NUM_CLASSES-1
//   m_valid_o/m_ready_i      result handshake; m_class_o argmax index, m_score_o its logit
//   busy_o                   low only when idle in LOAD with no pixels taken
//   err_frame_o              pulse: frame length mismatch
//   err_timeout_o            pulse: logits did not all return within TIMEOUT cycles
//   err_spurious_o           pulse: logit strobe outside WAIT
module mnist_frame_core
  import mnist_defs::*;
#(
  parameter int unsigned IMG_W       = IMG_W_DEF,
  parameter int unsigned IMG_H       = IMG_H_DEF,
  parameter int unsigned PIX_W       = PIX_W_DEF,
  parameter int unsigned LOGIT_W     = LOGIT_W_DEF,
  parameter int unsigned NUM_CLASSES = NUM_CLASSES_DEF,
  parameter int unsigned TIMEOUT     = TIMEOUT_DEF
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic                               s_valid_i,
  output logic                               s_ready_o,
  input  logic        [PIX_W-1:0]            s_pixel_i,
  input  logic                               s_last_i,
  output logic                               net_valid_o,
  output logic        [PIX_W-1:0]            net_pixel_o,
  input  logic                               net_logit_valid_i,
  input  logic signed [LOGIT_W-1:0]          net_logit_i,
  output logic                               m_valid_o,
  input  logic                               m_ready_i,
  output logic        [$clog2(NUM_CLASSES)-1:0] m_class_o,
  output logic signed [LOGIT_W-1:0]          m_score_o,
  output logic                               busy_o,
  output logic                               err_frame_o,
  output logic                               err_timeout_o,
  output logic                               err_spurious_o
);

  localparam int unsigned N         = IMG_W * IMG_H;
  localparam int unsigned PIX_CNT_W = $clog2(N + 1);
  localparam int unsigned CNT_W     = $clog2(NUM_CLASSES + 1);
  localparam int unsigned WDOG_W    = $clog2(TIMEOUT + 1);

  localparam logic [PIX_CNT_W-1:0] PixLast  = PIX_CNT_W'(N - 1);
  localparam logic [CNT_W-1:0]     ClsLast  = CNT_W'(NUM_CLASSES - 1);
  localparam logic [WDOG_W-1:0]    WdogLast = WDOG_W'(TIMEOUT);

  state_e                 state_q;
  logic [PIX_CNT_W-1:0]   pix_cnt_q;
  logic [WDOG_W-1:0]      wdog_q;
  logic                   net_valid_q;
  logic [PIX_W-1:0]       net_pixel_q;
  logic                   m_valid_q;
  logic                   err_frame_q, err_timeout_q, err_spurious_q;

  logic                   s_fire;
  logic                   frame_done;
  logic                   logit_take;
  logic                   last_logit;
  logic [CNT_W-1:0]       cls_cnt;

  assign s_ready_o  = (state_q == StLoad);
  assign s_fire     = s_valid_i & s_ready_o;
  // N-th pixel going to layer1 this cycle, either a real beat or a pad.
  assign frame_done = (pix_cnt_q == PixLast) &&
                      (((state_q == StLoad) && s_fire) || (state_q == StPad));
  assign logit_take = net_logit_valid_i && (state_q == StWait);
  assign last_logit = logit_take && (cls_cnt == ClsLast);

  // The argmax registers double as the result registers: they are only written
  // in WAIT, so they stay stable through HOLD.
  mnist_argmax_seq #(
    .LOGIT_W    (LOGIT_W),
    .NUM_CLASSES(NUM_CLASSES)
  ) u_argmax (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .clear_i   (frame_done),
    .valid_i   (logit_take),
    .data_i    (net_logit_i),
    .best_idx_o(m_class_o),
    .best_val_o(m_score_o),
    .count_o   (cls_cnt)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= StLoad;
      pix_cnt_q      <= '0;
      wdog_q         <= '0;
      net_valid_q    <= 1'b0;
      net_pixel_q    <= '0;
      m_valid_q      <= 1'b0;
      err_frame_q    <= 1'b0;
      err_timeout_q  <= 1'b0;
      err_spurious_q <= 1'b0;
    end else begin
      net_valid_q    <= 1'b0;
      err_frame_q    <= 1'b0;
      err_timeout_q  <= 1'b0;
      err_spurious_q <= net_logit_valid_i && (state_q != StWait);
      case (state_q)
        StLoad: begin
          if (s_fire) begin
            net_valid_q <= 1'b1;
            net_pixel_q <= s_pixel_i;
            if (pix_cnt_q == PixLast) begin
              // Missing s_last: close this frame anyway; later beats start the next.
              err_frame_q <= ~s_last_i;
              pix_cnt_q   <= '0;
              wdog_q      <= '0;
              state_q     <= StWait;
            end else begin
              pix_cnt_q <= pix_cnt_q + PIX_CNT_W'(1);
              if (s_last_i) begin
                err_frame_q <= 1'b1;
                state_q     <= StPad;
              end
            end
          end
        end
        StPad: begin
          net_valid_q <= 1'b1;
          net_pixel_q <= '0;
          if (pix_cnt_q == PixLast) begin
            pix_cnt_q <= '0;
            wdog_q    <= '0;
            state_q   <= StWait;
          end else begin
            pix_cnt_q <= pix_cnt_q + PIX_CNT_W'(1);
          end
        end
        StWait: begin
          wdog_q <= wdog_q + WDOG_W'(1);
          // Final logit takes priority over a watchdog expiring in the same cycle.
          if (last_logit) begin
            m_valid_q <= 1'b1;
            state_q   <= StHold;
          end else if (wdog_q == WdogLast) begin
            err_timeout_q <= 1'b1;
            state_q       <= StLoad;
          end
        end
        StHold: begin
          if (m_ready_i) begin
            m_valid_q <= 1'b0;
            state_q   <= StLoad;
          end
        end
        default: state_q <= StLoad;
      endcase
    end
  end

  assign net_valid_o    = net_valid_q;
  assign net_pixel_o    = net_pixel_q;
  assign m_valid_o      = m_valid_q;
  assign busy_o         = !((state_q == StLoad) && (pix_cnt_q == '0));
  assign err_frame_o    = err_frame_q;
  assign err_timeout_o  = err_timeout_q;
  assign err_spurious_o = err_spurious_q;

endmodule

// File: tb/tb_mnist_frame_core.sv
// Self-checking bench for mnist_frame_core (28x28 frames, 10 classes, TIMEOUT=50).
module tb_mnist_frame_core;

  localparam int NPIX = 28 * 28;
  localparam int TO   = 50;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               s_valid, s_ready, s_last;
  logic [7:0]         s_pixel;
  logic               net_valid;
  logic [7:0]         net_pixel;
  logic               lv;
  logic signed [31:0] logit;
  logic               m_valid, m_ready;
  logic [3:0]         m_class;
  logic signed [31:0] m_score;
  logic               busy, err_frame, err_timeout, err_spurious;

  always #5 clk = ~clk;

  mnist_frame_core #(
    .IMG_W(28), .IMG_H(28), .PIX_W(8), .LOGIT_W(32), .NUM_CLASSES(10), .TIMEOUT(TO)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .s_valid_i(s_valid), .s_ready_o(s_ready), .s_pixel_i(s_pixel), .s_last_i(s_last),
    .net_valid_o(net_valid), .net_pixel_o(net_pixel),
    .net_logit_valid_i(lv), .net_logit_i(logit),
    .m_valid_o(m_valid), .m_ready_i(m_ready), .m_class_o(m_class), .m_score_o(m_score),
    .busy_o(busy), .err_frame_o(err_frame), .err_timeout_o(err_timeout),
    .err_spurious_o(err_spurious)
  );

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int ef_cnt = 0, et_cnt = 0, es_cnt = 0, mv_cnt = 0;
  logic signed [31:0] lg [10];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (err_frame)    ef_cnt++;
    if (err_timeout)  et_cnt++;
    if (err_spurious) es_cnt++;
    if (m_valid)      mv_cnt++;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: observed no finish, required finish within 2ms");
    $fatal(1, "bench time limit");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: largest logit, lowest index on ties.
  function automatic void ref_argmax(output int idx, output logic signed [31:0] val);
    idx = 0;
    val = lg[0];
    for (int i = 1; i < 10; i++) if (lg[i] > val) begin idx = i; val = lg[i]; end
  endfunction

  task automatic fill_logits(input bit narrow);
    for (int i = 0; i < 10; i++)
      lg[i] = narrow ? $signed($urandom_range(0, 12)) - 6 : $signed($urandom);
  endtask

  // Every beat is offered while LOAD; each must reappear on net_* one cycle later.
  task automatic send_beats(input int nbeats, input int last_at, output int bad);
    logic [7:0] pix;
    bad = 0;
    for (int i = 1; i <= nbeats; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        s_valid = 1'b0;
        tick();
      end
      pix = 8'($urandom);
      s_valid = 1'b1;
      s_pixel = pix;
      s_last  = (i == last_at);
      if (s_ready !== 1'b1) bad++;
      tick();
      if (!(net_valid === 1'b1 && net_pixel === pix)) bad++;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic drive_logits(input int nlog, input int gap_max, output int bad);
    int ng;
    bad = 0;
    for (int i = 0; i < nlog; i++) begin
      if (i > 0) begin
        ng = $urandom_range(0, gap_max);
        for (int g = 0; g < ng; g++) begin
          lv = 1'b0;
          tick();
        end
      end
      if (m_valid !== 1'b0) bad++;
      lv = 1'b1;
      logit = lg[i];
      tick();
    end
    lv = 1'b0;
  endtask

  task automatic check_result(input string tag);
    int eidx;
    logic signed [31:0] eval;
    ref_argmax(eidx, eval);
    check({tag, "_m_valid"}, m_valid, 1);
    check({tag, "_m_class"}, m_class, eidx[3:0]);
    check({tag, "_m_score"}, m_score, eval);
  endtask

  task automatic handshake(input string tag);
    int nd;
    nd = $urandom_range(0, 3);
    for (int i = 0; i < nd; i++) tick();
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    check({tag, "_m_valid_drop"}, m_valid, 0);
    check({tag, "_s_ready_back"}, s_ready, 1);
  endtask

  initial begin
    int bad, pad, t0, ef0, et0, es0, mv0, eidx;
    logic signed [31:0] eval;
    logic [3:0] cls_hold;
    logic signed [31:0] score_hold;

    rst_n = 1'b0; s_valid = 1'b0; s_pixel = '0; s_last = 1'b0;
    lv = 1'b0; logit = '0; m_ready = 1'b0;
    #1;
    check("rst_s_ready", s_ready, 1);
    check("rst_net_valid", net_valid, 0);
    check("rst_net_pixel", net_pixel, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_class", m_class, 0);
    check("rst_m_score", m_score, 0);
    check("rst_busy", busy, 0);
    check("rst_errs", {err_frame, err_timeout, err_spurious}, 0);
    #21 rst_n = 1'b1;
    tick();

    // A: full frame with s_last on beat 784, fixed logits with a tie.
    send_beats(NPIX, NPIX, bad);
    check("a_beats", bad, 0);
    check("a_s_ready_wait", s_ready, 0);
    check("a_busy_wait", busy, 1);
    lg = '{-5, 3, 9, 9, 0, -1, 2, 1, -8, 4};
    drive_logits(10, 2, bad);
    check("a_early_mvalid", bad, 0);
    check_result("a");
    check("a_class_const", m_class, 2);
    check("a_score_const", m_score, 9);
    handshake("a");
    check("a_busy_idle", busy, 0);
    check("a_no_errs", ef_cnt + et_cnt + es_cnt, 0);

    // Spurious logit in LOAD.
    lv = 1'b1; logit = 32'sd77;
    tick();
    lv = 1'b0;
    check("load_spurious", err_spurious, 1);
    tick();
    check("load_spurious_pulse", err_spurious, 0);

    // B: short frame, s_last on beat 100, then 684 zero pads on consecutive cycles.
    send_beats(100, 100, bad);
    check("b_beats", bad, 0);
    check("b_err_frame", err_frame, 1);
    pad = 0;
    for (int c = 0; c < 2000; c++) begin
      tick();
      if (net_valid === 1'b1 && net_pixel === 8'd0) pad++;
      else break;
    end
    check("b_pad_count", pad, NPIX - 100);
    check("b_s_ready_wait", s_ready, 0);
    fill_logits(1'b1);
    drive_logits(10, 2, bad);
    check("b_early_mvalid", bad, 0);
    check_result("b");
    handshake("b");

    // C: 784 beats without s_last, then 3 beats that open the next frame.
    ef0 = ef_cnt;
    send_beats(NPIX, 0, bad);
    check("c_beats", bad, 0);
    check("c_err_frame", err_frame, 1);
    check("c_s_ready_wait", s_ready, 0);
    fill_logits(1'b0);
    drive_logits(10, 2, bad);
    check_result("c");
    handshake("c");
    send_beats(3, 0, bad);
    check("c_next_beats", bad, 0);
    check("c_next_busy", busy, 1);
    send_beats(NPIX - 3, NPIX - 3, bad);
    check("c_rest_beats", bad, 0);
    check("c_rest_no_err", err_frame, 0);
    check("c_rest_s_ready", s_ready, 0);
    check("c_err_frame_count", ef_cnt - ef0, 1);

    // D: only 9 logits, watchdog fires 51 cycles after WAIT entry.
    t0 = cyc;
    mv0 = mv_cnt;
    et0 = et_cnt;
    fill_logits(1'b1);
    drive_logits(9, 1, bad);
    for (int c = 0; c < 200; c++) begin
      if (err_timeout === 1'b1) break;
      tick();
    end
    check("d_timeout_seen", err_timeout, 1);
    check("d_timeout_delay", cyc - t0, TO + 1);
    check("d_s_ready_after", s_ready, 1);
    tick();
    check("d_no_mvalid", mv_cnt - mv0, 0);
    check("d_timeout_pulses", et_cnt - et0, 1);

    // E: result held 20 cycles with m_ready low, spurious strobe during HOLD.
    send_beats(NPIX, NPIX, bad);
    check("e_beats", bad, 0);
    fill_logits(1'b0);
    drive_logits(10, 2, bad);
    check_result("e");
    ref_argmax(eidx, eval);
    cls_hold = eidx[3:0];
    score_hold = eval;
    bad = 0;
    es0 = es_cnt;
    for (int c = 0; c < 20; c++) begin
      if (!(m_valid === 1'b1 && m_class === cls_hold && m_score === score_hold &&
            s_ready === 1'b0)) bad++;
      lv = (c == 5);
      logit = 32'sh7fff_ffff;
      tick();
      lv = 1'b0;
      if (c == 5) check("e_hold_spurious", err_spurious, 1);
    end
    check("e_hold_stable", bad, 0);
    check("e_spurious_count", es_cnt - es0, 1);
    handshake("e");

    // G: 10th logit lands in the same cycle the watchdog expires.
    send_beats(NPIX, NPIX, bad);
    check("g_beats", bad, 0);
    et0 = et_cnt;
    fill_logits(1'b1);
    for (int c = 0; c <= TO; c++) begin
      lv = (c < 9) || (c == TO);
      logit = (c < 9) ? lg[c] : lg[9];
      tick();
    end
    lv = 1'b0;
    check_result("g");
    check("g_no_timeout", err_timeout, 0);
    tick();
    check("g_no_timeout_pulse", et_cnt - et0, 0);
    handshake("g");

    // F: reset at pixel 400, then a clean frame.
    send_beats(400, 0, bad);
    check("f_beats", bad, 0);
    #2 rst_n = 1'b0;
    #1;
    check("f_rst_net_valid", net_valid, 0);
    check("f_rst_net_pixel", net_pixel, 0);
    check("f_rst_busy", busy, 0);
    check("f_rst_s_ready", s_ready, 1);
    check("f_rst_m", {m_valid, m_class, m_score}, 0);
    check("f_rst_errs", {err_frame, err_timeout, err_spurious}, 0);
    #2 rst_n = 1'b1;
    tick();
    ef0 = ef_cnt;
    send_beats(NPIX, NPIX, bad);
    check("f_frame_beats", bad, 0);
    fill_logits(1'b0);
    drive_logits(10, 2, bad);
    check_result("f");
    handshake("f");
    check("f_no_frame_err", ef_cnt - ef0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mnist_frame_core.md
# mnist_frame_core

Parametrised successor to the fixed MNIST network core. It adds frame sequencing around the layer1→layer4 datapath:
- ready/valid pixel intake with frame-length checking and zero-padding of short frames;
- one-frame-in-flight control;
- a watchdog on the logit return path;
- a sequential argmax that turns the serial logit stream into a class index with a backpressured result handshake.

It sits between the pixel source (UART/DMA side) and the layer blocks. Internally it drives the layer1 `valid_in`/`pixel_in` pair and consumes the layer4 `out_valid`/`out_data` pair.

## Interface
- IMG_W, 28, image width in pixels
- IMG_H, 28, image height in pixels
- PIX_W, 8, pixel width
- LOGIT_W, 32, logit width, signed two's complement
- NUM_CLASSES, 10, logits per frame
- TIMEOUT, 65535, maximum WAIT cycles before abort
- clk  in  1  single clock
- rst_n  in  1  reset, asynchronous, active-low
- s_valid  in  1  pixel beat valid
- s_ready  out  1  pixel beat accepted when s_valid & s_ready
- s_pixel  in  PIX_W  pixel value
- s_last  in  1  marks final pixel of the frame
- net_valid  out  1  pixel strobe to layer1
- net_pixel  out  PIX_W  pixel to layer1
- net_logit_valid  in  1  logit strobe from layer4
- net_logit  in  LOGIT_W  logit from layer4, classes in index order 0..NUM_CLASSES-1
- m_valid  out  1  result valid, held until m_ready
- m_ready  in  1  result consumer ready
- m_class  out  CLS_W  argmax index, CLS_W = $clog2(NUM_CLASSES)
- m_score  out  LOGIT_W  winning logit
- busy  out  1  high in any state other than LOAD with pix_cnt==0
- err_frame  out  1  one-cycle pulse: frame length mismatch
- err_timeout  out  1  one-cycle pulse: WAIT watchdog expired
- err_spurious  out  1  one-cycle pulse: net_logit_valid outside WAIT

## Operation
- N = IMG_W*IMG_H. Counters:
  - pix_cnt: $clog2(N+1) bits
  - cls_cnt: $clog2(NUM_CLASSES+1) bits
  - wdog: $clog2(TIMEOUT+1) bits
- States: LOAD (reset state), PAD, WAIT, HOLD.
- LOAD:
  - s_ready=1.
  - Each accepted beat is registered onto net_pixel/net_valid, and pix_cnt increments.
  - If s_last arrives at pix_cnt<N-1: err_frame pulses and the FSM goes to PAD.
  - On the N-th beat without s_last: err_frame pulses, the frame completes normally, and later beats belong to the next frame.
  - On the N-th beat (with or without s_last): go to WAIT, clear best/cls_cnt/wdog.
- PAD:
  - s_ready=0.
  - Issues net_valid with net_pixel=0, one per cycle, until N pixels total have been sent, then goes to WAIT.
- WAIT:
  - s_ready=0; wdog increments every cycle.
  - Each net_logit_valid beat is compared signed against best. The first beat always loads best. Later beats replace best only if strictly greater, so ties keep the lower index.
  - When cls_cnt reaches NUM_CLASSES, go to HOLD.
  - If wdog==TIMEOUT before that, err_timeout pulses and the FSM returns to LOAD with no result.
- HOLD:
  - m_valid=1; m_class/m_score are stable.
  - On m_valid & m_ready, go to LOAD.
- net_logit_valid in LOAD/PAD/HOLD: the beat is discarded and err_spurious pulses.
- If the final logit and watchdog expiry land in the same cycle, the logit wins: go to HOLD, no err_timeout.
- Reset mid-operation clears all state and outputs immediately; the layer blocks share rst_n.

## Timing
- Reset values:
  - 0: net_valid, net_pixel, m_valid, m_class, m_score, busy, err_frame, err_timeout, err_spurious.
  - 1: s_ready (LOAD).
- s_ready is decoded from the state register only. It has no combinational path from s_valid or m_ready.
- Pixel latency: net_valid/net_pixel appear 1 cycle after the accepting edge.
- Result latency: m_valid rises 1 cycle after the NUM_CLASSES-th net_logit_valid.
- Back-to-back: s_ready rises the cycle after the m_ready handshake.
- err_* pulses are registered and fire 1 cycle after the causing event.

## Structure
- Shared package/header `mnist_defs`:
  - default IMG_W, IMG_H, PIX_W, LOGIT_W, NUM_CLASSES;
  - state encodings LOAD=0, PAD=1, WAIT=2, HOLD=3.
- One sub-module, `mnist_argmax_seq`:
  - inputs: clear, valid, signed data;
  - outputs: best index, best value, count;
  - parametrised on LOGIT_W and NUM_CLASSES.
- The top holds the FSM, pixel/pad path, watchdog and result registers.

## Test plan
- Full frame of 784 beats, s_last on beat 784, then logits {-5,3,9,9,0,-1,2,1,-8,4} → m_class=2, m_score=9, no error pulses.
- s_last on beat 100 → err_frame pulse, 684 zero-pixel net_valid strobes on consecutive cycles, then normal WAIT.
- 784 beats without s_last, then 3 further beats → err_frame pulse; the 3 beats count as pix_cnt=3 of the next frame.
- Only 9 logits return, TIMEOUT=50 → err_timeout 51 cycles after WAIT entry, m_valid never asserts, s_ready=1 afterwards.
- m_ready held low for 20 cycles in HOLD → m_valid/m_class stable, s_ready=0 throughout; logit strobe during HOLD → err_spurious.
- rst_n asserted at pixel 400 → all outputs at reset values the same cycle; the next full frame classifies correctly.
